// File: rtl/muldiv_unit_if.sv
// Handshake and HI/LO bus between the register-file side and the multiply/divide unit.
// Combinational bundle only; all timing is set by muldiv_unit.
// No backpressure: a new start is simply ignored while busy is high.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wd;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wd,
    input  busy, done, div0, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wd,
    output busy, done, div0, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers; divider built only with MULDIV_DIV_EN.
// Latency: accept on edge N, result and one-cycle done on edge N+33 (divide without divider: N+1).
// Backpressure: busy high from accept to completion; start and HI/LO writes are ignored meanwhile.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic reset,
  muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;      // product, or {remainder, dividend/quotient}
  logic [WIDTH-1:0]   mcand_q, mcand_d;  // multiplicand or divisor magnitude
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               sgn_q, sgn_d;      // negate product / quotient at FIN
`ifdef MULDIV_DIV_EN
  logic               sgn_r_q, sgn_r_d;  // negate remainder at FIN
  logic               dz_q, dz_d;        // divisor was zero
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
`endif

  logic               signed_op;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;

  // Next-state logic: operand capture, one iteration per cycle, sign fix-up and HI/LO update at FIN
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    div0_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sgn_d    = sgn_q;

    signed_op = ~bus.op[0];
    a_mag     = (signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_mag     = (signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
`ifdef MULDIV_DIV_EN
    sgn_r_d   = sgn_r_q;
    dz_d      = dz_q;
    // Bring down the next dividend bit and trial-subtract the divisor
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, mcand_q};
`endif

    case (state_q)
      IDLE: begin
        if (bus.hi_we) hi_d = bus.wd;
        if (bus.lo_we) lo_d = bus.wd;
        if (bus.start) begin
          busy_d   = 1'b1;
          cnt_d    = '0;
          is_div_d = bus.op[1];
          sgn_d    = signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          if (!bus.op[1]) begin
            state_d = MUL;
            mcand_d = a_mag;
            acc_d   = {{WIDTH{1'b0}}, b_mag};
          end else begin
`ifdef MULDIV_DIV_EN
            state_d = DIV;
            mcand_d = b_mag;
            acc_d   = {{WIDTH{1'b0}}, a_mag};
            sgn_r_d = signed_op & bus.a[WIDTH-1];
            dz_d    = (bus.b == '0);
`else
            // No divider: complete immediately without touching HI/LO
            state_d = FIN;
`endif
          end
        end
      end
      MUL: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIN;
      end
      DIV: begin
`ifdef MULDIV_DIV_EN
        if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else                  acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIN;
`else
        state_d = FIN;
`endif
      end
      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (!is_div_q) begin
          {hi_d, lo_d} = sgn_q ? -acc_q : acc_q;
        end
`ifdef MULDIV_DIV_EN
        else begin
          // A zero divisor leaves the dividend as remainder; quotient is forced to all ones
          hi_d   = sgn_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
          lo_d   = dz_q ? '1 : (sgn_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
          div0_d = dz_q;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sgn_q    <= 1'b0;
`ifdef MULDIV_DIV_EN
      sgn_r_q  <= 1'b0;
      dz_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sgn_q    <= sgn_d;
`ifdef MULDIV_DIV_EN
      sgn_r_q  <= sgn_r_d;
      dz_q     <= dz_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.div0 = div0_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random operations
// compared against an arithmetic reference model of HI/LO, done latency and div0.
module tb_muldiv_unit;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;
  logic [31:0] mdl_hi;
  logic [31:0] mdl_lo;

  muldiv_unit_if bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Expected outcome of one operation, from plain integer arithmetic
  task automatic model(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                       output logic [31:0] eh, output logic [31:0] el,
                       output logic ed, output int elat);
    longint      sp;
    logic [63:0] up;
    int          sa;
    int          sb;
    ed   = 1'b0;
    elat = 33;
    eh   = mdl_hi;
    el   = mdl_lo;
    sa   = a_i;
    sb   = b_i;
    if (op_i == 2'b00) begin
      sp = longint'(sa) * longint'(sb);
      {eh, el} = 64'(sp);
    end else if (op_i == 2'b01) begin
      up = {32'b0, a_i} * {32'b0, b_i};
      {eh, el} = up;
    end else begin
`ifdef MULDIV_DIV_EN
      if (b_i == 32'd0) begin
        eh = a_i;
        el = 32'hFFFF_FFFF;
        ed = 1'b1;
      end else if (op_i == 2'b10) begin
        if (a_i == 32'h8000_0000 && b_i == 32'hFFFF_FFFF) begin
          eh = 32'd0;
          el = 32'h8000_0000;
        end else begin
          el = 32'(sa / sb);
          eh = 32'(sa % sb);
        end
      end else begin
        el = a_i / b_i;
        eh = a_i % b_i;
      end
`else
      elat = 1;
`endif
    end
  endtask

  // Issue one operation, optionally with an HI write in the accept cycle and
  // optionally with a second start plus HI/LO writes injected while busy
  task automatic do_op(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                       input logic we_i, input logic [31:0] wd_i, input logic inject_i,
                       input string tag);
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic        exp_d0;
    int          exp_lat;
    int          lat;
    bus.start = 1'b1;
    bus.op    = op_i;
    bus.a     = a_i;
    bus.b     = b_i;
    bus.hi_we = we_i;
    bus.lo_we = 1'b0;
    bus.wd    = wd_i;
    if (we_i) mdl_hi = wd_i;
    pre_hi = mdl_hi;
    pre_lo = mdl_lo;
    model(op_i, a_i, b_i, exp_hi, exp_lo, exp_d0, exp_lat);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.op    = 2'($urandom);
    check({tag, "_busy_accept"}, 64'(bus.busy), 64'(1));
    check({tag, "_div0_busy"}, 64'(bus.div0), 64'(0));
    check({tag, "_hi_accept"}, 64'(bus.hi), 64'(pre_hi));
    lat = 0;
    while (!bus.done && lat < 40) begin
      if (inject_i && lat == 4) begin
        bus.start = 1'b1;
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wd    = 32'hDEAD_BEEF;
      end else begin
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (lat == 16) begin
        check({tag, "_hi_midop"}, 64'(bus.hi), 64'(pre_hi));
        check({tag, "_lo_midop"}, 64'(bus.lo), 64'(pre_lo));
      end
    end
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
    check({tag, "_div0"}, 64'(bus.div0), 64'(exp_d0));
    check({tag, "_busy_done"}, 64'(bus.busy), 64'(0));
    mdl_hi = exp_hi;
    mdl_lo = exp_lo;
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 64'(bus.done), 64'(0));
    check({tag, "_div0_pulse"}, 64'(bus.div0), 64'(0));
    if (inject_i) check({tag, "_inject_ignored"}, 64'(bus.busy), 64'(0));
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        saw_done;
    n_total   = 0;
    n_pass    = 0;
    mdl_hi    = '0;
    mdl_lo    = '0;
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wd    = '0;

    // Reset state, with start and an HI write attempted while held in reset
    @(posedge clk); #1;
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_div0", 64'(bus.div0), 64'(0));
    check("rst_hi", 64'(bus.hi), 64'(0));
    check("rst_lo", 64'(bus.lo), 64'(0));
    bus.start = 1'b1;
    bus.hi_we = 1'b1;
    bus.wd    = 32'h0000_0055;
    @(posedge clk); #1;
    check("rst_hold_busy", 64'(bus.busy), 64'(0));
    check("rst_hold_hi", 64'(bus.hi), 64'(0));
    bus.start = 1'b0;
    bus.hi_we = 1'b0;

    // First start right after reset release
    reset = 1'b1;
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0, "multu_max");
    check("multu_max_hi_const", 64'(bus.hi), 64'h0000_0000_FFFF_FFFE);
    check("multu_max_lo_const", 64'(bus.lo), 64'h0000_0000_0000_0001);
    do_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 32'd0, 1'b0, "mult_neg3x7");
    check("mult_neg3x7_lo_const", 64'(bus.lo), 64'h0000_0000_FFFF_FFEB);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'd0, 1'b0, "div_neg7by2");
    do_op(2'b11, 32'd100, 32'd0, 1'b0, 32'd0, 1'b0, "divu_by0");
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0, "div_ovf");
    do_op(2'b10, 32'hFFFF_FFF0, 32'd0, 1'b0, 32'd0, 1'b0, "div_neg_by0");

    // MTHI and MTLO in the same cycle, then MTHI alone
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wd    = 32'h0BAD_F00D;
    @(posedge clk); #1;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    check("mthilo_hi", 64'(bus.hi), 64'h0BAD_F00D);
    check("mthilo_lo", 64'(bus.lo), 64'h0BAD_F00D);
    bus.hi_we = 1'b1;
    bus.wd    = 32'h1234_5678;
    @(posedge clk); #1;
    bus.hi_we = 1'b0;
    check("mthi_hi", 64'(bus.hi), 64'h1234_5678);
    check("mthi_lo", 64'(bus.lo), 64'h0BAD_F00D);
    mdl_hi = 32'h1234_5678;
    mdl_lo = 32'h0BAD_F00D;

    // Second start and HI/LO writes while busy are ignored
    do_op(2'b01, 32'h0001_0003, 32'h0002_0005, 1'b0, 32'd0, 1'b1, "busy_inject");

    // HI write together with start: write lands, result later overwrites it
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'hCAFE_F00D, 1'b0, "start_mthi");
    do_op(2'b10, 32'd77, 32'd5, 1'b1, 32'h0F0F_0F0F, 1'b0, "start_mthi_div");

    // Reset asserted after edge N+10 of a MULTU abandons it
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.a     = 32'h1111_1111;
    bus.b     = 32'h0000_0010;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("midrst_busy", 64'(bus.busy), 64'(0));
    check("midrst_hi", 64'(bus.hi), 64'(0));
    check("midrst_lo", 64'(bus.lo), 64'(0));
    check("midrst_done", 64'(bus.done), 64'(0));
    mdl_hi = '0;
    mdl_lo = '0;
    @(posedge clk); #1;
    reset    = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) saw_done = 1'b1;
    end
    check("midrst_no_done", 64'(saw_done), 64'(0));
    check("midrst_hi_after", 64'(bus.hi), 64'(0));

    // Random operations
    for (int i = 0; i < 24; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      case ($urandom_range(0, 7))
        0:       r_b = 32'd0;
        1, 2:    r_b = $urandom_range(1, 50);
        3:       r_b = -$urandom_range(1, 50);
        default: r_b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) r_a = $urandom_range(0, 1000);
      do_op(r_op, r_a, r_b, 1'b0, 32'd0, 1'b0, $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
